// File: rtl/fetch_queue_mw.sv
// fetch_queue_mw: multi-way instruction queue between I-cache fetch and decode.
// Accepts up to ENQ_WIDTH {pc, inst} pairs per cycle, but only as a whole group.
// Presents the DEQ_WIDTH oldest entries to decode, which may consume any prefix
// of them. A flush on redirect discards everything.
// Occupancy comes from the difference of two pointers that carry a wrap bit.
// This lets a full queue be told apart from an empty one.

module fetch_queue_mw #(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 2,
    parameter int DEQ_WIDTH = 2,
    parameter int XLEN      = 32,
    parameter int AF_THRESH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [ENQ_WIDTH-1:0]           enq_valid,
    input  logic [ENQ_WIDTH*XLEN-1:0]      enq_pc,
    input  logic [ENQ_WIDTH*XLEN-1:0]      enq_inst,
    output logic                           enq_ready,
    output logic [DEQ_WIDTH-1:0]           deq_valid,
    output logic [DEQ_WIDTH*XLEN-1:0]      deq_pc,
    output logic [DEQ_WIDTH*XLEN-1:0]      deq_inst,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0] deq_take,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           almost_full,
    output logic                           empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ENQ_P   = PTR_W'(ENQ_WIDTH);
    // A threshold at or above DEPTH means almost_full is always set, so clamping keeps it representable.
    localparam logic [PTR_W-1:0] AF_P    = PTR_W'((AF_THRESH > DEPTH) ? DEPTH : AF_THRESH);

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] free;
    logic [PTR_W-1:0] n_enq;
    logic [PTR_W-1:0] n_deq;
    logic [PTR_W-1:0] take_ext;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             run;

    assign count       = wr_ptr - rd_ptr;
    assign free        = DEPTH_P - count;
    assign enq_ready   = (free >= ENQ_P);
    assign almost_full = (free <= AF_P);
    assign empty       = (count == '0);
    assign wr_idx      = wr_ptr[IDX_W-1:0];
    assign rd_idx      = rd_ptr[IDX_W-1:0];
    assign take_ext    = PTR_W'(deq_take);
    assign n_deq       = (take_ext > count) ? count : take_ext;

    // Count the valid lanes from lane 0 up to the first gap; later lanes are ignored.
    always_comb begin
        n_enq = '0;
        run   = 1'b1;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            run = run & enq_valid[i];
            if (run) begin
                n_enq = n_enq + PTR_W'(1);
            end
        end
    end

    // Write the accepted group into consecutive slots starting at the write pointer.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && enq_ready) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (PTR_W'(i) < n_enq) begin
                    pc_mem[wr_idx + IDX_W'(i)]   <= enq_pc[i*XLEN +: XLEN];
                    inst_mem[wr_idx + IDX_W'(i)] <= enq_inst[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Advance the pointers; reset and flush both collapse the queue to empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_ready) begin
                wr_ptr <= wr_ptr + n_enq;
            end
            rd_ptr <= rd_ptr + n_deq;
        end
    end

    // Present the oldest entries to decode straight from the array, with no bypass of this cycle's writes.
    always_comb begin
        deq_valid = '0;
        deq_pc    = '0;
        deq_inst  = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_valid[i]                = (count > PTR_W'(i));
            deq_pc[i*XLEN +: XLEN]      = pc_mem[rd_idx + IDX_W'(i)];
            deq_inst[i*XLEN +: XLEN]    = inst_mem[rd_idx + IDX_W'(i)];
        end
    end

endmodule
